frog_game_sequencer: RTL

Top-level game controller for frogger. Sits between the collision checker and the frog/car movers. Turns the raw death and win collision flags into a sequenced game: start, play, death pause, level-up pause, game over and victory. It owns the level and lives counters, the round-reset pulse, and the freeze signal that holds frog and cars still during pauses.

---
 rtl/frogger_pkg.sv | 19 +
 rtl/frame_pause_timer.sv | 20 ++
 rtl/frog_game_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// frogger_pkg: shared frogger game types, widths, default game constants and BCD helper
package frogger_pkg;
  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    DYING,
    LEVEL_UP,
    GAME_OVER,
    VICTORY
  } game_state_t;
  localparam int LEVEL_W = 4;
  localparam int LIVES_W = 2;
  localparam int DEF_MAX_LEVEL = 8;
  localparam int DEF_START_LIVES = 3;
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    return v == 8'h99 ? v :
           v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/frame_pause_timer.sv
// frame_pause_timer: counts frame ticks during a pause and pulses done on the terminal tick
module frame_pause_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             frame_tick,
  input  logic [CNT_W-1:0] terminal,
  output logic             done
);
  logic [CNT_W-1:0] count;
  assign done = en & frame_tick & (count == terminal);
  // frame counter, held at zero outside pauses so every pause starts from zero
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (en && frame_tick) count <= count + CNT_W'(1);
endmodule

// File: rtl/frog_game_sequencer.sv
// frog_game_sequencer: frogger game FSM owning level, lives, round reset and freeze; FROG_SCORE_EN adds a BCD score
module frog_game_sequencer
  import frogger_pkg::*;
#(
  parameter int MAX_LEVEL      = DEF_MAX_LEVEL,
  parameter int START_LIVES    = DEF_START_LIVES,
  parameter int DEATH_FRAMES   = 60,
  parameter int LEVELUP_FRAMES = 90,
  parameter int CNT_W          = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               death_collision,
  input  logic               win_collision,
  output logic               round_reset,
  output logic               freeze,
  output logic [LEVEL_W-1:0] current_level,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic               victory
`ifdef FROG_SCORE_EN
  ,
  output logic [7:0]         score
`endif
);
  game_state_t state;
  logic start_q;
  logic start_rise;
  logic pause_done;
  logic [CNT_W-1:0] terminal;
  assign start_rise = start & ~start_q;
  assign freeze     = state != PLAY;
  assign game_over  = state == GAME_OVER;
  assign victory    = state == VICTORY;
  assign terminal   = state == DYING ? CNT_W'(DEATH_FRAMES - 1) : CNT_W'(LEVELUP_FRAMES - 1);
  frame_pause_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state == PLAY),
    .en         (state == DYING || state == LEVEL_UP),
    .frame_tick (frame_tick),
    .terminal   (terminal),
    .done       (pause_done)
  );
  // game FSM; collisions are ignored during the round_reset cycle because the frog position is stale
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      current_level <= '0;
      lives         <= LIVES_W'(START_LIVES);
      round_reset   <= 1'b0;
      start_q       <= 1'b1;
`ifdef FROG_SCORE_EN
      score         <= '0;
`endif
    end else begin
      start_q     <= start;
      round_reset <= 1'b0;
      case (state)
        IDLE, GAME_OVER, VICTORY:
          if (start_rise) begin
            current_level <= '0;
            lives         <= LIVES_W'(START_LIVES);
            round_reset   <= 1'b1;
            state         <= PLAY;
`ifdef FROG_SCORE_EN
            score         <= '0;
`endif
          end
        PLAY:
          if (!round_reset) begin
            if (win_collision) begin
              if (current_level < LEVEL_W'(MAX_LEVEL)) begin
                current_level <= current_level + LEVEL_W'(1);
                state         <= LEVEL_UP;
              end else state <= VICTORY;
`ifdef FROG_SCORE_EN
              score <= bcd_inc_sat(score);
`endif
            end else if (death_collision) begin
              if (lives > LIVES_W'(1)) begin
                lives <= lives - LIVES_W'(1);
                state <= DYING;
              end else begin
                lives <= '0;
                state <= GAME_OVER;
              end
            end
          end
        DYING, LEVEL_UP:
          if (pause_done) begin
            round_reset <= 1'b1;
            state       <= PLAY;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
